// File: rtl/rv32_pkg.sv
// rv32_pkg -- shared definitions for the rv32_core codebase slice.
//   Opcode, funct3 and funct7 encodings of the supported RV32I subset.
//   alu_op_e   : operation selected for the inline ALU.
//   imm_type_e : immediate layout (I/S/B/J) for the immediate generator.
//   gen_imm()  : sign-extended immediate for a given layout.
package rv32_pkg;

    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_type_e;

    function automatic logic [31:0] gen_imm(logic [31:0] ins, imm_type_e t);
        logic [31:0] v;
        case (t)
            IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// rv32_regfile -- 32 x 32-bit integer register file.
//   clk, rst         : clock, synchronous active-high reset (clears every register)
//   raddr1 / rdata1  : combinational read port 1
//   raddr2 / rdata2  : combinational read port 2
//   we, waddr, wdata : write port, committed on posedge clk
// x0 always reads as zero and ignores writes.
module rv32_regfile
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [0:NREGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rv32_core.sv
// rv32_core -- single-cycle RV32I-subset core with internal instruction memory.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (pc <= 0, registers cleared)
//   pc         : address of the instruction executing this cycle
//   instr      : instruction word fetched from imem.memory at pc
//   mem_read   : load this cycle
//   mem_write  : store this cycle (data memory writes on the next posedge)
//   mem_addr   : rs1 + sign-extended offset (byte address)
//   mem_wdata  : rs2 for stores, zero otherwise
//   mem_rdata  : load data, combinational from mem_addr
// Build option: define RV32_CORE_BRANCH_EN to enable BEQ/BNE/BLT/BGE/BLTU/BGEU,
// JAL and JALR; otherwise those opcodes execute as NOPs.
module rv32_core
    import rv32_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    // Instruction store; contents are loaded from outside the design.
    if (1) begin : imem
        logic [31:0] memory [0:IMEM_DEPTH-1];
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] rd_wdata;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    alu_op_e     alu_op;
    imm_type_e   imm_type;
    logic        use_imm;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_link;
`ifdef RV32_CORE_BRANCH_EN
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
`endif

    function automatic alu_op_e decode_alu(logic [2:0] f3, logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned(sa >>> b[4:0]);
            ALU_SLT:  r = {31'd0, sa < sb};
            ALU_SLTU: r = {31'd0, a < b};
            default:  r = a + b;
        endcase
        return r;
    endfunction

`ifdef RV32_CORE_BRANCH_EN
    function automatic logic branch_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               t;
        sa = a;
        sb = b;
        case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = (sa < sb);
            F3_BGE:  t = (sa >= sb);
            F3_BLTU: t = (a < b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction
`endif

    // Fetch: pc[1:0] are ignored and the word index wraps over IMEM_DEPTH.
    assign instr    = imem.memory[pc[IDX_W+1:2]];
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rd_addr  = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign pc_plus4 = pc + 32'd4;

    // Decode: anything not recognised leaves every control low, i.e. a NOP.
    always_comb begin
        alu_op   = ALU_ADD;
        imm_type = IMM_I;
        use_imm  = 1'b0;
        reg_we   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_link  = 1'b0;
`ifdef RV32_CORE_BRANCH_EN
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))) begin
                    reg_we = 1'b1;
                    alu_op = decode_alu(funct3, funct7[5]);
                end
            end
            OP_IMM: begin
                use_imm = 1'b1;
                // Shift-immediates carry funct7 in imm[11:5]; other I-ALU ops
                // treat those bits as immediate, so bit 30 must not select SUB.
                if (!((funct3 == F3_SLL && funct7 != F7_BASE) ||
                      (funct3 == F3_SRL_SRA && funct7 != F7_BASE && funct7 != F7_ALT))) begin
                    reg_we = 1'b1;
                    alu_op = decode_alu(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    use_imm = 1'b1;
                    reg_we  = 1'b1;
                    is_load = 1'b1;
                end
            end
            OP_STORE: begin
                imm_type = IMM_S;
                if (funct3 == F3_SW) begin
                    use_imm  = 1'b1;
                    is_store = 1'b1;
                end
            end
`ifdef RV32_CORE_BRANCH_EN
            OP_BRANCH: begin
                imm_type  = IMM_B;
                is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_JAL: begin
                imm_type = IMM_J;
                reg_we   = 1'b1;
                is_link  = 1'b1;
                is_jal   = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    use_imm = 1'b1;
                    reg_we  = 1'b1;
                    is_link = 1'b1;
                    is_jalr = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign imm        = gen_imm(instr, imm_type);
    assign alu_b      = use_imm ? imm : rs2_data;
    assign alu_result = alu(alu_op, rs1_data, alu_b);
    assign rd_wdata   = is_load ? mem_rdata : (is_link ? pc_plus4 : alu_result);

    always_comb begin
        next_pc = pc_plus4;
`ifdef RV32_CORE_BRANCH_EN
        if (is_jal || (is_branch && branch_taken(funct3, rs1_data, rs2_data))) begin
            next_pc = pc + imm;
        end else if (is_jalr) begin
            next_pc = {alu_result[31:1], 1'b0};
        end
`endif
    end

    // Data port: reset suppresses any access so memory stays untouched.
    assign mem_addr  = rs1_data + imm;
    assign mem_read  = is_load && !rst;
    assign mem_write = is_store && !rst;
    assign mem_wdata = is_store ? rs2_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end

    rv32_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1_addr),
        .rdata1 (rs1_data),
        .raddr2 (rs2_addr),
        .rdata2 (rs2_data),
        .we     (reg_we && !rst),
        .waddr  (rd_addr),
        .wdata  (rd_wdata)
    );

endmodule

// File: tb/tb_rv32_core.sv
`timescale 1ns/1ps
module tb_rv32_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32_core #(.IMEM_DEPTH(256), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .instr     (instr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // External data memory: 16 words, combinational read, write on posedge.
    logic [31:0] dmem [0:15];
    logic        dm_load = 1'b0;

    assign mem_rdata = dmem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (dm_load) begin
            for (int i = 0; i < 16; i++) dmem[i] <= (i < 3) ? 32'(10 * (i + 1)) : 32'd0;
        end else if (mem_write) begin
            dmem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.imem.memory[i] = 32'd0;
    endtask

    // Holds rst for two posedges (optionally reloading data memory); returns
    // at a negedge with rst still high.
    task automatic hold_reset(input logic reload);
        @(negedge clk);
        rst     = 1'b1;
        dm_load = reload;
        @(negedge clk);
        @(negedge clk);
        dm_load = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd;
        logic        wr;
        logic        chk_addr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cyc_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] exp;
    } alu_t;

    cyc_t cyc_tab [0:3];
    alu_t alu_tab [0:28];

    initial begin
        cyc_tab[0] = '{pc: 32'h0, instr: 32'h00002083, rd: 1'b1, wr: 1'b0, chk_addr: 1'b1, addr: 32'd0, wdata: 32'd0};
        cyc_tab[1] = '{pc: 32'h4, instr: 32'h00402103, rd: 1'b1, wr: 1'b0, chk_addr: 1'b1, addr: 32'd4, wdata: 32'd0};
        cyc_tab[2] = '{pc: 32'h8, instr: 32'h002081B3, rd: 1'b0, wr: 1'b0, chk_addr: 1'b0, addr: 32'd0, wdata: 32'd0};
        cyc_tab[3] = '{pc: 32'hC, instr: 32'h00302223, rd: 1'b0, wr: 1'b1, chk_addr: 1'b1, addr: 32'd4, wdata: 32'd30};

        alu_tab[0]  = '{enc_i(12'hFFF, 5'd0, 3'b000, 5'd5),  5'd5,  32'hFFFFFFFF}; // addi x5,x0,-1
        alu_tab[1]  = '{enc_i(12'h01C, 5'd5, 3'b101, 5'd6),  5'd6,  32'h0000000F}; // srli x6,x5,28
        alu_tab[2]  = '{enc_i(12'h404, 5'd5, 3'b101, 5'd8),  5'd8,  32'hFFFFFFFF}; // srai x8,x5,4
        alu_tab[3]  = '{enc_r(7'h00, 5'd5, 5'd0, 3'b011, 5'd7), 5'd7, 32'h00000001}; // sltu x7,x0,x5
        alu_tab[4]  = '{enc_i(12'h7FF, 5'd0, 3'b000, 5'd9),  5'd9,  32'h000007FF}; // addi x9,x0,2047
        alu_tab[5]  = '{enc_r(7'h20, 5'd9, 5'd0, 3'b000, 5'd10), 5'd10, 32'hFFFFF801}; // sub
        alu_tab[6]  = '{enc_r(7'h00, 5'd9, 5'd10, 3'b010, 5'd11), 5'd11, 32'h00000001}; // slt signed
        alu_tab[7]  = '{enc_r(7'h00, 5'd10, 5'd9, 3'b011, 5'd12), 5'd12, 32'h00000001}; // sltu
        alu_tab[8]  = '{enc_r(7'h00, 5'd6, 5'd9, 3'b001, 5'd13), 5'd13, 32'h03FF8000}; // sll by 15
        alu_tab[9]  = '{enc_r(7'h00, 5'd5, 5'd13, 3'b100, 5'd14), 5'd14, 32'hFC007FFF}; // xor
        alu_tab[10] = '{enc_r(7'h00, 5'd9, 5'd14, 3'b111, 5'd15), 5'd15, 32'h000007FF}; // and
        alu_tab[11] = '{enc_r(7'h00, 5'd6, 5'd10, 3'b110, 5'd16), 5'd16, 32'hFFFFF80F}; // or
        alu_tab[12] = '{enc_r(7'h00, 5'd6, 5'd10, 3'b101, 5'd17), 5'd17, 32'h0001FFFF}; // srl by 15
        alu_tab[13] = '{enc_r(7'h20, 5'd11, 5'd10, 3'b101, 5'd18), 5'd18, 32'hFFFFFC00}; // sra by 1
        alu_tab[14] = '{enc_i(12'h802, 5'd10, 3'b010, 5'd19), 5'd19, 32'h00000001}; // slti -2046
        alu_tab[15] = '{enc_i(12'h555, 5'd5, 3'b100, 5'd20), 5'd20, 32'hFFFFFAAA}; // xori
        alu_tab[16] = '{enc_i(12'hFF0, 5'd14, 3'b111, 5'd21), 5'd21, 32'hFC007FF0}; // andi -16
        alu_tab[17] = '{enc_i(12'h123, 5'd0, 3'b110, 5'd22), 5'd22, 32'h00000123}; // ori
        alu_tab[18] = '{enc_i(12'h015, 5'd9, 3'b001, 5'd23), 5'd23, 32'hFFE00000}; // slli 21
        alu_tab[19] = '{enc_i(12'h001, 5'd0, 3'b011, 5'd24), 5'd24, 32'h00000001}; // sltiu 1
        alu_tab[20] = '{enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd25), 5'd25, 32'hFFFFFFFE}; // add wraps
        alu_tab[21] = '{32'h00000000, 5'd0, 32'h00000000};                            // instr=0
        alu_tab[22] = '{enc_i(12'h005, 5'd0, 3'b000, 5'd0), 5'd0, 32'h00000000};   // addi x0,x0,5
        alu_tab[23] = '{enc_i(12'h007, 5'd0, 3'b000, 5'd26), 5'd26, 32'h00000007}; // x0 reads 0
        alu_tab[24] = '{enc_r(7'h01, 5'd5, 5'd5, 3'b000, 5'd27), 5'd27, 32'h00000000}; // bad funct7
        alu_tab[25] = '{enc_i(12'h401, 5'd5, 3'b001, 5'd28), 5'd28, 32'h00000000}; // bad slli f7
        alu_tab[26] = '{enc_i(12'hFFF, 5'd9, 3'b011, 5'd29), 5'd29, 32'h00000001}; // sltiu -1
        alu_tab[27] = '{enc_i(12'h400, 5'd9, 3'b000, 5'd30), 5'd30, 32'h00000BFF}; // addi, bit30 set
        alu_tab[28] = '{{12'h000, 5'd0, 3'b000, 5'd31, 7'b0000011}, 5'd31, 32'h00000000}; // lb: NOP

        // ---- Program A: load / load / add / store ----
        clear_imem();
        dut.imem.memory[0] = 32'h00002083;
        dut.imem.memory[1] = 32'h00402103;
        dut.imem.memory[2] = 32'h002081B3;
        dut.imem.memory[3] = 32'h00302223;
        hold_reset(1'b1);
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("progA_pc[%0d]", i), pc, cyc_tab[i].pc);
            chk($sformatf("progA_instr[%0d]", i), instr, cyc_tab[i].instr);
            chk($sformatf("progA_rd[%0d]", i), 32'(mem_read), 32'(cyc_tab[i].rd));
            chk($sformatf("progA_wr[%0d]", i), 32'(mem_write), 32'(cyc_tab[i].wr));
            chk($sformatf("progA_wdata[%0d]", i), mem_wdata, cyc_tab[i].wdata);
            if (cyc_tab[i].chk_addr) chk($sformatf("progA_addr[%0d]", i), mem_addr, cyc_tab[i].addr);
            @(negedge clk);
        end
        #1;
        chk("progA_x1", dut.u_regfile.regs[1], 32'd10);
        chk("progA_x2", dut.u_regfile.regs[2], 32'd20);
        chk("progA_x3", dut.u_regfile.regs[3], 32'd30);
        chk("progA_mem0", dmem[0], 32'd10);
        chk("progA_mem1", dmem[1], 32'd30);
        chk("progA_mem2", dmem[2], 32'd30);

        // ---- Reset for two cycles while the store is executing ----
        hold_reset(1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_pc_before", pc, 32'hC);
        rst = 1'b1;
        #1;
        chk("midrst_no_write", 32'(mem_write), 32'd0);
        chk("midrst_no_read0", 32'(mem_read), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_no_read1", 32'(mem_read), 32'd0);
        chk("midrst_no_write1", 32'(mem_write), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_pc", pc, 32'h0);
        for (int r = 1; r < 32; r++) chk($sformatf("midrst_x%0d", r), dut.u_regfile.regs[r], 32'd0);
        chk("midrst_mem1_kept", dmem[1], 32'd20);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("restart_pc", pc, 32'h10);
        chk("restart_x3", dut.u_regfile.regs[3], 32'd30);
        chk("restart_mem1", dmem[1], 32'd30);

        // ---- ALU / NOP table, one instruction per cycle ----
        clear_imem();
        for (int i = 0; i < 29; i++) dut.imem.memory[i] = alu_tab[i].instr;
        hold_reset(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 29; i++) begin
            #1;
            chk($sformatf("alu_pc[%0d]", i), pc, 32'(4 * i));
            @(negedge clk);
            #1;
            chk($sformatf("alu_x%0d[%0d]", alu_tab[i].rd, i), dut.u_regfile.regs[alu_tab[i].rd], alu_tab[i].exp);
        end

        // ---- beq x0,x0,-8 at 0x10 ----
        clear_imem();
        dut.imem.memory[4] = 32'hFE000CE3;
        hold_reset(1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("beq_at", pc, 32'h10);
        @(negedge clk);
        #1;
`ifdef RV32_CORE_BRANCH_EN
        chk("beq_target", pc, 32'h08);
`else
        chk("beq_nop", pc, 32'h14);
`endif

        // ---- jal x1,+16 at 0x20 ----
        clear_imem();
        dut.imem.memory[8] = 32'h010000EF;
        hold_reset(1'b0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("jal_at", pc, 32'h20);
        @(negedge clk);
        #1;
`ifdef RV32_CORE_BRANCH_EN
        chk("jal_target", pc, 32'h30);
        chk("jal_link", dut.u_regfile.regs[1], 32'h24);
`else
        chk("jal_nop_pc", pc, 32'h24);
        chk("jal_nop_x1", dut.u_regfile.regs[1], 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
